mem_wb_pipeline_reg: RTL and testbench

MEM_WB_PIPELINE_REG -- requirements
Module: mem_wb_pipeline_reg

---
 rtl/mem_wb_pipeline_reg_pkg.sv | 16 +
 rtl/mem_wb_pipeline_reg.sv | 74 +++++++
 tb/tb_mem_wb_pipeline_reg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipeline_reg_pkg.sv
// Shared CPU definitions for the MEM/WB stage: default field widths and the
// write-back source encodings decoded downstream by the write-back multiplexer.
package mem_wb_pipeline_reg_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_RD_WIDTH    = 5;
  localparam int DEF_WBSEL_WIDTH = 2;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_DMEM = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/mem_wb_pipeline_reg.sv
// MEM/WB pipeline register: captures all fields together each cycle, holds them
// while memory stalls, and clears them on a synchronous active-low reset.
module mem_wb_pipeline_reg
  import mem_wb_pipeline_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_WIDTH    = DEF_RD_WIDTH,
  parameter int WBSEL_WIDTH = DEF_WBSEL_WIDTH
) (
  input  logic [RD_WIDTH-1:0]    IN_INSTRUCTION,
  input  logic [DATA_WIDTH-1:0]  IN_PC_4,
  input  logic [DATA_WIDTH-1:0]  IN_ALU_RESULT,
  input  logic [DATA_WIDTH-1:0]  IN_IMMEDIATE,
  input  logic [DATA_WIDTH-1:0]  IN_DMEM_OUT,
  input  logic [WBSEL_WIDTH-1:0] IN_WB_SEL,
  input  logic                   IN_REG_WRITE_EN,
  output logic [RD_WIDTH-1:0]    OUT_INSTRUCTION,
  output logic [DATA_WIDTH-1:0]  OUT_PC_4,
  output logic [DATA_WIDTH-1:0]  OUT_ALU_RESULT,
  output logic [DATA_WIDTH-1:0]  OUT_IMMEDIATE,
  output logic [DATA_WIDTH-1:0]  OUT_DMEM_OUT,
  output logic [WBSEL_WIDTH-1:0] OUT_WB_SEL,
  output logic                   OUT_REG_WRITE_EN,
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   BUSYWAIT
);

  logic [RD_WIDTH-1:0]    instruction_r;
  logic [DATA_WIDTH-1:0]  pc_4_r;
  logic [DATA_WIDTH-1:0]  alu_result_r;
  logic [DATA_WIDTH-1:0]  immediate_r;
  logic [DATA_WIDTH-1:0]  dmem_out_r;
  logic [WBSEL_WIDTH-1:0] wb_sel_r;
  logic                   reg_write_en_r;

  // Field register: reset outranks the stall hold so a stalled stage can still be flushed.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      instruction_r  <= '0;
      pc_4_r         <= '0;
      alu_result_r   <= '0;
      immediate_r    <= '0;
      dmem_out_r     <= '0;
      wb_sel_r       <= '0;
      reg_write_en_r <= 1'b0;
    end else if (!BUSYWAIT) begin
      instruction_r  <= IN_INSTRUCTION;
      pc_4_r         <= IN_PC_4;
      alu_result_r   <= IN_ALU_RESULT;
      immediate_r    <= IN_IMMEDIATE;
      dmem_out_r     <= IN_DMEM_OUT;
      wb_sel_r       <= IN_WB_SEL;
      reg_write_en_r <= IN_REG_WRITE_EN;
    end else begin
      instruction_r  <= instruction_r;
      pc_4_r         <= pc_4_r;
      alu_result_r   <= alu_result_r;
      immediate_r    <= immediate_r;
      dmem_out_r     <= dmem_out_r;
      wb_sel_r       <= wb_sel_r;
      reg_write_en_r <= reg_write_en_r;
    end
  end

  assign OUT_INSTRUCTION  = instruction_r;
  assign OUT_PC_4         = pc_4_r;
  assign OUT_ALU_RESULT   = alu_result_r;
  assign OUT_IMMEDIATE    = immediate_r;
  assign OUT_DMEM_OUT     = dmem_out_r;
  assign OUT_WB_SEL       = wb_sel_r;
  assign OUT_REG_WRITE_EN = reg_write_en_r;

endmodule

// File: tb/tb_mem_wb_pipeline_reg.sv
// Directed bench for mem_wb_pipeline_reg: reset, capture, stall hold/release,
// reset priority over stall, and between-edge stability.
module tb_mem_wb_pipeline_reg;

  logic        clk_s;
  logic        reset_s;
  logic        busywait_s;
  logic [4:0]  in_instruction_s;
  logic [31:0] in_pc_4_s;
  logic [31:0] in_alu_result_s;
  logic [31:0] in_immediate_s;
  logic [31:0] in_dmem_out_s;
  logic [1:0]  in_wb_sel_s;
  logic        in_reg_write_en_s;
  logic [4:0]  out_instruction_s;
  logic [31:0] out_pc_4_s;
  logic [31:0] out_alu_result_s;
  logic [31:0] out_immediate_s;
  logic [31:0] out_dmem_out_s;
  logic [1:0]  out_wb_sel_s;
  logic        out_reg_write_en_s;

  int chk_cnt_r  = 0;
  int pass_cnt_r = 0;

  mem_wb_pipeline_reg dut (
    .IN_INSTRUCTION   (in_instruction_s),
    .IN_PC_4          (in_pc_4_s),
    .IN_ALU_RESULT    (in_alu_result_s),
    .IN_IMMEDIATE     (in_immediate_s),
    .IN_DMEM_OUT      (in_dmem_out_s),
    .IN_WB_SEL        (in_wb_sel_s),
    .IN_REG_WRITE_EN  (in_reg_write_en_s),
    .OUT_INSTRUCTION  (out_instruction_s),
    .OUT_PC_4         (out_pc_4_s),
    .OUT_ALU_RESULT   (out_alu_result_s),
    .OUT_IMMEDIATE    (out_immediate_s),
    .OUT_DMEM_OUT     (out_dmem_out_s),
    .OUT_WB_SEL       (out_wb_sel_s),
    .OUT_REG_WRITE_EN (out_reg_write_en_s),
    .CLK              (clk_s),
    .RESET            (reset_s),
    .BUSYWAIT         (busywait_s)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt_r++;
    if (obs === exp) pass_cnt_r++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] dm,
                           input logic [1:0] ws, input logic we);
    check_val({tag, ".rd"},   {27'd0, out_instruction_s}, {27'd0, rd});
    check_val({tag, ".pc4"},  out_pc_4_s, pc);
    check_val({tag, ".alu"},  out_alu_result_s, alu);
    check_val({tag, ".imm"},  out_immediate_s, imm);
    check_val({tag, ".dmem"}, out_dmem_out_s, dm);
    check_val({tag, ".wsel"}, {30'd0, out_wb_sel_s}, {30'd0, ws});
    check_val({tag, ".we"},   {31'd0, out_reg_write_en_s}, {31'd0, we});
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] imm, input logic [31:0] dm, input logic [1:0] ws,
                       input logic we);
    in_instruction_s  = rd;
    in_pc_4_s         = pc;
    in_alu_result_s   = alu;
    in_immediate_s    = imm;
    in_dmem_out_s     = dm;
    in_wb_sel_s       = ws;
    in_reg_write_en_s = we;
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  initial begin
    reset_s    = 1'b1;
    busywait_s = 1'b0;
    drive(5'd15, 32'd23, 32'd45, 32'd56, 32'd35, 2'b01, 1'b1);

    // Reset edge with live inputs clears everything.
    @(negedge clk_s);
    reset_s = 1'b0;
    tick();
    check_all("reset", 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);

    // One-cycle capture.
    @(negedge clk_s);
    reset_s = 1'b1;
    tick();
    check_all("load1", 5'd15, 32'd23, 32'd45, 32'd56, 32'd35, 2'b01, 1'b1);

    // Stall holds old contents while inputs change.
    @(negedge clk_s);
    busywait_s = 1'b1;
    drive(5'd10, 32'd20, 32'd40, 32'd50, 32'd38, 2'b11, 1'b0);
    tick();
    check_all("stall", 5'd15, 32'd23, 32'd45, 32'd56, 32'd35, 2'b01, 1'b1);

    // Stall release captures the inputs present at that edge.
    @(negedge clk_s);
    busywait_s = 1'b0;
    tick();
    check_all("release", 5'd10, 32'd20, 32'd40, 32'd50, 32'd38, 2'b11, 1'b0);

    // Reset wins over stall.
    @(negedge clk_s);
    busywait_s = 1'b1;
    drive(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1);
    reset_s = 1'b0;
    tick();
    check_all("rst_stall", 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);

    // Reset released while still stalled: stays cleared, then all-ones captured on release.
    @(negedge clk_s);
    reset_s = 1'b1;
    tick();
    check_all("post_rst_hold", 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    @(negedge clk_s);
    busywait_s = 1'b0;
    tick();
    check_all("ones", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1);

    // Distinct bit patterns per field catch swapped or truncated fields.
    @(negedge clk_s);
    drive(5'd21, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h8000_0001, 32'h0123_4567, 2'b10, 1'b0);
    tick();
    check_all("pattern", 5'd21, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h8000_0001, 32'h0123_4567, 2'b10, 1'b0);

    // Multi-cycle stall with inputs changing each cycle; last value wins on release.
    @(negedge clk_s);
    busywait_s = 1'b1;
    drive(5'd1, 32'd1, 32'd2, 32'd3, 32'd4, 2'b01, 1'b1);
    tick();
    @(negedge clk_s);
    drive(5'd2, 32'd5, 32'd6, 32'd7, 32'd8, 2'b00, 1'b0);
    tick();
    check_all("stall2", 5'd21, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h8000_0001, 32'h0123_4567, 2'b10, 1'b0);
    @(negedge clk_s);
    busywait_s = 1'b0;
    drive(5'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 1'b1);
    tick();
    check_all("release2", 5'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 1'b1);

    // Reset pulse between edges and mid-cycle input toggles: no output change.
    @(negedge clk_s);
    reset_s = 1'b0;
    drive(5'd9, 32'd90, 32'd91, 32'd92, 32'd93, 2'b10, 1'b0);
    #2;
    reset_s = 1'b1;
    drive(5'd12, 32'd120, 32'd121, 32'd122, 32'd123, 2'b11, 1'b0);
    #1;
    check_all("midcycle", 5'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 1'b1);
    tick();
    check_all("after_glitch", 5'd12, 32'd120, 32'd121, 32'd122, 32'd123, 2'b11, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt_r, chk_cnt_r);
    $finish;
  end

endmodule
